// File: rtl/aec_expr_feeder.sv
// Host-side feeder for the arithmetic expression calculator: filters and buffers one
// '='-terminated expression, replays it to the AEC, then waits for a result or a watchdog.
module aec_expr_feeder #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [6:0] ascii_out,
    output logic       aec_ready,
    input  logic       aec_valid,
    output logic       busy,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = 8;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        SEND     = 2'd1,
        WAIT_RES = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] rd_ptr;
    logic          discard;
    logic [WW-1:0] wdog;
    logic [6:0]    expr_buf [DEPTH];

    logic [6:0]    ch_c;
    logic          is_space_c;
    logic          storable_c;
    logic          is_eq_c;
    logic          accept_c;
    logic          full_c;
    logic          store_c;

    // Character classification; uppercase hex letters fold to lowercase before storage.
    always_comb begin
        ch_c       = in_data[6:0];
        is_space_c = (in_data == 8'h20);
        storable_c = 1'b0;
        if (in_data >= 8'h41 && in_data <= 8'h46) begin
            ch_c = in_data[6:0] + 7'h20;
        end
        if (!in_data[7]) begin
            if ((ch_c >= 7'h30 && ch_c <= 7'h39) ||
                (ch_c >= 7'h61 && ch_c <= 7'h66) ||
                (ch_c >= 7'h28 && ch_c <= 7'h2b) ||
                (ch_c == 7'h2d) || (ch_c == 7'h3d)) begin
                storable_c = 1'b1;
            end
        end
        is_eq_c = storable_c && (ch_c == 7'h3d);
    end

    assign accept_c = in_valid && in_ready && (state == COLLECT);
    assign full_c   = (count == CW'(DEPTH - 1));
    assign store_c  = accept_c && storable_c && !discard &&
                      (is_eq_c ? (count != '0) : !full_c);

    // Expression storage needs no reset; count gates what is ever read back.
    always_ff @(posedge clk) begin
        if (store_c) begin
            expr_buf[count[AW-1:0]] <= ch_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= COLLECT;
            count     <= '0;
            rd_ptr    <= '0;
            discard   <= 1'b0;
            wdog      <= '0;
            in_ready  <= 1'b0;
            ascii_out <= '0;
            aec_ready <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            err <= 1'b0;
            case (state)
                COLLECT: begin
                    in_ready <= 1'b1;
                    if (accept_c && !is_space_c) begin
                        if (discard) begin
                            // Swallow the rest of a broken expression up to its '='.
                            if (is_eq_c) begin
                                count   <= '0;
                                discard <= 1'b0;
                            end
                        end else if (!storable_c) begin
                            err      <= 1'b1;
                            err_code <= 2'd1;
                            discard  <= 1'b1;
                        end else if (is_eq_c) begin
                            if (count != '0) begin
                                count     <= count + 1'b1;
                                rd_ptr    <= CW'(1);
                                ascii_out <= expr_buf[0];
                                aec_ready <= 1'b1;
                                busy      <= 1'b1;
                                in_ready  <= 1'b0;
                                state     <= SEND;
                            end
                        end else if (full_c) begin
                            err      <= 1'b1;
                            err_code <= 2'd2;
                            discard  <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (rd_ptr == count) begin
                        aec_ready <= 1'b0;
                        ascii_out <= '0;
                        wdog      <= '0;
                        state     <= WAIT_RES;
                    end else begin
                        ascii_out <= expr_buf[rd_ptr[AW-1:0]];
                        rd_ptr    <= rd_ptr + 1'b1;
                    end
                end
                WAIT_RES: begin
                    // A result arriving on the timeout cycle still counts as success.
                    if (aec_valid) begin
                        count    <= '0;
                        wdog     <= '0;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= COLLECT;
                    end else if ((wdog + 8'd1) == WW'(TIMEOUT)) begin
                        err      <= 1'b1;
                        err_code <= 2'd3;
                        count    <= '0;
                        wdog     <= '0;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= COLLECT;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule
